seven_seg_scan_driver: RTL

- Parametrised successor to the combinational hex-to-seven-segment decoder.
- Owns the anode scan itself: an internal prescaler steps a digit index across NUM_DIGITS common-anode digits.
- Per-digit 4-bit values are captured into a shadow buffer and applied only at frame boundaries, so the display never tears.
- Adds per-digit blanking, decimal points, leading-zero suppression and anti-ghosting dead time.
- Sits between the lab datapath (A, B, sum, difference, any hex values) and the board's anode/segment pins.

---
 rtl/seven_seg_scan_if.sv | 26 ++
 rtl/seven_seg_scan_driver.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_if.sv
// Bundle between a hex-value producer and the multiplexed seven-segment scan driver.
// The producer side (master) supplies digit data and strobes; the driver side (slave) returns pin-level outputs.
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    load;
    logic                    lzs_en;
    logic [NUM_DIGITS-1:0]   anode;
    logic [6:0]              segs;
    logic                    dp;
    logic                    frame_tick;
    logic                    update_pending;

    modport master (
        output digits, dp_in, blank_in, load, lzs_en,
        input  anode, segs, dp, frame_tick, update_pending
    );

    modport slave (
        input  digits, dp_in, blank_in, load, lzs_en,
        output anode, segs, dp, frame_tick, update_pending
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode seven-segment driver with tear-free shadow buffering,
// per-digit blanking, decimal points, leading-zero suppression and anti-ghost dead time.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 0
) (
    input logic             clk,
    input logic             rst_n,
    seven_seg_scan_if.slave bus
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0]         PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

    logic [PW-1:0]              prescaler_r;
    logic [IW-1:0]              index_r;
    logic [NUM_DIGITS-1:0][3:0] shadow_digits_r;
    logic [NUM_DIGITS-1:0][3:0] active_digits_r;
    logic [NUM_DIGITS-1:0]      shadow_dp_r;
    logic [NUM_DIGITS-1:0]      shadow_blank_r;
    logic [NUM_DIGITS-1:0]      active_dp_r;
    logic [NUM_DIGITS-1:0]      active_blank_r;
    logic                       pending_r;
    logic                       lzs_r;
    logic [NUM_DIGITS-1:0]      anode_r;
    logic [6:0]                 segs_r;
    logic                       dp_r;
    logic                       frame_tick_r;

    logic                       terminal_s;
    logic                       wrap_s;
    logic                       dead_s;
    logic                       zero_run_s;
    logic [NUM_DIGITS-1:0]      suppress_s;
    logic [NUM_DIGITS-1:0]      anode_s;
    logic [6:0]                 segs_s;
    logic                       dp_s;

    function automatic logic [6:0] decode_hex(input logic [3:0] value);
        case (value)
            4'h0: decode_hex = 7'h40;
            4'h1: decode_hex = 7'h79;
            4'h2: decode_hex = 7'h24;
            4'h3: decode_hex = 7'h30;
            4'h4: decode_hex = 7'h19;
            4'h5: decode_hex = 7'h12;
            4'h6: decode_hex = 7'h02;
            4'h7: decode_hex = 7'h78;
            4'h8: decode_hex = 7'h00;
            4'h9: decode_hex = 7'h10;
            4'hA: decode_hex = 7'h08;
            4'hB: decode_hex = 7'h03;
            4'hC: decode_hex = 7'h46;
            4'hD: decode_hex = 7'h21;
            4'hE: decode_hex = 7'h06;
            4'hF: decode_hex = 7'h0E;
            default: decode_hex = 7'h7F;
        endcase
    endfunction

    assign terminal_s = (prescaler_r == PRE_LAST);
    assign wrap_s     = terminal_s && (index_r == IDX_LAST);

    // The dead window only exists when DEAD_CYCLES is non-zero; avoids a constant compare.
    generate
        if (DEAD_CYCLES > 0) begin : g_dead
            localparam logic [PW-1:0] DEAD_LAST = PW'(DEAD_CYCLES);
            assign dead_s = (prescaler_r < DEAD_LAST);
        end else begin : g_no_dead
            assign dead_s = 1'b0;
        end
    endgenerate

    // Prescaler and digit index scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_r <= '0;
            index_r     <= '0;
        end else if (terminal_s) begin
            prescaler_r <= '0;
            index_r     <= wrap_s ? '0 : index_r + IW'(1);
        end else begin
            prescaler_r <= prescaler_r + PW'(1);
        end
    end

    // Shadow capture on load; shadow-to-active transfer only at the frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_digits_r <= '0;
            shadow_dp_r     <= '0;
            shadow_blank_r  <= '0;
            active_digits_r <= '0;
            active_dp_r     <= '0;
            active_blank_r  <= '0;
            pending_r       <= 1'b0;
            lzs_r           <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow_digits_r <= bus.digits;
                shadow_dp_r     <= bus.dp_in;
                shadow_blank_r  <= bus.blank_in;
            end
            // Transfer reads the pre-load shadow, so a load on the wrap cycle stays pending.
            if (wrap_s) begin
                lzs_r <= bus.lzs_en;
                if (pending_r) begin
                    active_digits_r <= shadow_digits_r;
                    active_dp_r     <= shadow_dp_r;
                    active_blank_r  <= shadow_blank_r;
                end
            end
            pending_r <= bus.load ? 1'b1 : (wrap_s ? 1'b0 : pending_r);
        end
    end

    // Leading-zero mask: a digit is suppressed while it and all digits above it are zero.
    always_comb begin
        suppress_s = '0;
        zero_run_s = lzs_r;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run_s    = zero_run_s && (active_digits_r[i] == 4'h0);
            suppress_s[i] = zero_run_s;
        end
    end

    // Next value of the pin outputs for the currently selected digit.
    always_comb begin
        anode_s = '1;
        segs_s  = 7'h7F;
        dp_s    = 1'b1;
        if (dead_s) begin
            anode_s = '1;
        end else begin
            anode_s = ~(ONE_HOT0 << index_r);
            if (active_blank_r[index_r] || suppress_s[index_r]) begin
                segs_s = 7'h7F;
                dp_s   = 1'b1;
            end else begin
                segs_s = decode_hex(active_digits_r[index_r]);
                dp_s   = ~active_dp_r[index_r];
            end
        end
    end

    // Registered pin outputs and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_r      <= '1;
            segs_r       <= 7'h7F;
            dp_r         <= 1'b1;
            frame_tick_r <= 1'b0;
        end else begin
            anode_r      <= anode_s;
            segs_r       <= segs_s;
            dp_r         <= dp_s;
            frame_tick_r <= wrap_s;
        end
    end

    assign bus.anode          = anode_r;
    assign bus.segs           = segs_r;
    assign bus.dp             = dp_r;
    assign bus.frame_tick     = frame_tick_r;
    assign bus.update_pending = pending_r;
endmodule
